multicycle_core_p: RTL and testbench
====================================

Name: multicycle_core_p

Overview:
- Parametrised successor to the 8-bit four-register multicycle CPU.
- Data path width is DATA_W. Instruction encoding stays 8-bit, taken from the low byte of the fetched word.
- Memory is external, behind a req/ack handshake with arbitrary wait states, so the core can sit on a shared bus or slow RAM instead of a fixed one-cycle memory.
- Exposes PC, flags, FSM state and r0..r3 for the board's HEX/LED debug logic.

Parameters:
- DATA_W, 8, data/address width; legal when >= 8.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high. Clears every register, flag and the FSM.
- mem_req  out  1  memory request; held until ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  DATA_W  address; stable while mem_req.
- mem_wdata  out  DATA_W  store data; stable while mem_req.
- mem_rdata  in  DATA_W  read data; sampled on the edge where mem_ack=1.
- mem_ack  in  1  transfer complete; may be combinational from mem_req.
- pc  out  DATA_W  current PC.
- flag_n, flag_z  out  1  condition flags.
- state  out  4  FSM state code.
- r0, r1, r2, r3  out  DATA_W  register file contents.

Behaviour:
- Reset values:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - pc=PC_RESET; r0..r3=0; IR=0; flag_n=flag_z=0; state=FETCH (0).
  - Reset mid-transaction drops mem_req immediately; the pending access is abandoned.
- Instruction fields:
  - IR[7:6]=rA, IR[5:4]=rB, IR[3:0]=op.
  - imm5=IR[7:3], zero-extended. imm4=IR[7:4], sign-extended to DATA_W.
- Opcodes:
  - 0000 LOAD: rA<=mem[rB].
  - 0010 STORE: mem[rB]<=rA.
  - 0100 ADD: rA<=rA+rB.
  - 0110 SUB: rA<=rA-rB.
  - 1000 NAND: rA<=~(rA&rB).
  - x111 ORI: r1<=r1|imm5.
  - x011 SHIFT: rA shifted by IR[4:3] bits; IR[5]=0 left, 1 logical right; amount 0 leaves rA unchanged.
  - 0101 BZ: taken if Z. 1001 BNZ: taken if !Z. 1101 BPZ: taken if !N.
  - Branch target: PC<=PC+imm4, where PC is already incremented.
  - 0001, 1100, 1110 are NOP. 1010 is NOP unless the optional feature is compiled in.
- Arithmetic and flags:
  - All arithmetic is modulo 2^DATA_W.
  - N=result[DATA_W-1], Z=(result==0).
  - Flags are written only by ADD, SUB, NAND, ORI, SHIFT and MUL; all other instructions leave them unchanged.
- FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MUL=5.
  - FETCH: req read at PC. On ack: IR<=rdata[7:0], PC<=PC+1, go to DECODE.
  - DECODE: OpA<=rA, OpB<=rB.
    - LOAD/STORE go to MEM.
    - Branch and NOP go to EXEC.
    - MUL goes to MUL.
    - All others go to EXEC.
  - EXEC:
    - ALU ops: ALUOut and flags written, go to WB.
    - Branch: PC updated if taken, go to FETCH.
    - NOP: go to FETCH.
  - MEM: req at OpB.
    - STORE: we=1, wdata=OpA; on ack go to FETCH.
    - LOAD: on ack MDR<=rdata, go to WB.
  - WB: register write, go to FETCH.
- Handshake rules:
  - mem_req rises only on FSM entry to FETCH or MEM.
  - mem_addr, mem_we and mem_wdata are constant until the ack edge; mem_req is deasserted after it.
  - Every cycle with req=1 and ack=0 stalls the FSM in place with no state change.
  - mem_ack while mem_req=0 is ignored.
- Latency with zero-wait memory (ack same cycle):
  - ALU ops: 4 cycles.
  - LOAD: 4 cycles. STORE: 3 cycles.
  - Branch and NOP: 3 cycles.
  - Each wait state adds 1 cycle.
- Boundary cases:
  - PC wraps from 2^DATA_W-1 to 0.
  - A branch to PC+imm4 wraps modulo 2^DATA_W.
  - A register written in WB is visible to the next instruction's DECODE.

Optional Feature:
- Macro: MULTICYCLE_CORE_MUL_EN.
- Defined: opcode 1010 is MUL, rA<=low DATA_W bits of rA*rB, computed by a shift-add sequencer in state MUL.
  - Takes exactly DATA_W cycles in MUL, then WB.
  - N/Z are set from the truncated product.
  - Reset during MUL aborts the operation; rA is left unmodified.
- Undefined: 1010 is a NOP (3 cycles). No multiplier logic is synthesised, and state 5 is never entered.

Test Plan:
- Reset with DATA_W=8, PC_RESET=0: all outputs zero, state=0, mem_req asserts the first cycle after reset is released, with mem_addr=0.
- Zero-wait memory, program ORI 5; ADD r0,r1; SUB r0,r0 -> r1=5, r0=5 then 0, Z=1 after SUB. Each instruction takes 4 cycles.
- LOAD r2,[r1], with r1=0x10, mem[0x10]=0xA5, ack delayed 3 cycles -> mem_addr=0x10 held for all 3 wait cycles, r2=0xA5, N/Z unchanged.
- BNZ imm4=-3 with Z=0 at PC=0x08 -> next fetch address 0x06. Same instruction with Z=1 -> next fetch address 0x09.
- DATA_W=16, PC at 0xFFFF executes NOP -> next fetch at 0x0000. SHIFT right by 3 of 0x8000 -> 0x1000, N=0.
- MUL_EN defined, DATA_W=8: r0=0x13, r1=0x11, MUL r0,r1 -> r0=0x43, 8 cycles in MUL. Assert reset at the 4th MUL cycle -> all registers 0, state=FETCH.

Source files
------------

// File: rtl/multicycle_core_p_if.sv
// Memory bus between the multicycle core (master) and external memory (slave).
// req/ack handshake with any number of wait states; ack may be combinational from req.
interface multicycle_core_p_if #(
   parameter int unsigned DATA_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/multicycle_core_p.sv
// Parametrised four-register multicycle CPU with 8-bit instructions and a req/ack memory bus.
// Define MULTICYCLE_CORE_MUL_EN to turn opcode 1010 into a shift-add multiply (state MUL).
module multicycle_core_p #(
   parameter int unsigned       DATA_W   = 8,
   parameter logic [DATA_W-1:0] PC_RESET = '0
) (
   input  logic                clock,
   input  logic                reset,
   multicycle_core_p_if.master mem,
   output logic [DATA_W-1:0]   pc,
   output logic                flag_n,
   output logic                flag_z,
   output logic [3:0]          state,
   output logic [DATA_W-1:0]   r0,
   output logic [DATA_W-1:0]   r1,
   output logic [DATA_W-1:0]   r2,
   output logic [DATA_W-1:0]   r3
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC   = 4'd2,
      MEM    = 4'd3,
      WB     = 4'd4,
      MUL    = 4'd5
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [7:0]        ir_q, ir_d;
   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] regs_d [4];
   logic [DATA_W-1:0] opA_q, opA_d;
   logic [DATA_W-1:0] opB_q, opB_d;
   logic [DATA_W-1:0] aluOut_q, aluOut_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              flagN_q, flagN_d;
   logic              flagZ_q, flagZ_d;

   logic              memReq;
   logic              memWe;
   logic [DATA_W-1:0] memAddr;
   logic [DATA_W-1:0] memWdata;

   logic [3:0]        op;
   logic [1:0]        rA, rB, wbDest;
   logic              isLoad, isStore, isAdd, isSub, isNand, isOri, isShift;
   logic              isBz, isBnz, isBpz, isAlu, branchTaken;
   logic [DATA_W-1:0] imm5, imm4, aluResult;

   assign op      = ir_q[3:0];
   assign rA      = ir_q[7:6];
   assign rB      = ir_q[5:4];
   assign isLoad  = (op == 4'b0000);
   assign isStore = (op == 4'b0010);
   assign isAdd   = (op == 4'b0100);
   assign isSub   = (op == 4'b0110);
   assign isNand  = (op == 4'b1000);
   assign isOri   = (op[2:0] == 3'b111);
   assign isShift = (op[2:0] == 3'b011);
   assign isBz    = (op == 4'b0101);
   assign isBnz   = (op == 4'b1001);
   assign isBpz   = (op == 4'b1101);
   assign isAlu   = isAdd | isSub | isNand | isOri | isShift;

   assign branchTaken = (isBz & flagZ_q) | (isBnz & ~flagZ_q) | (isBpz & ~flagN_q);

   // ORI always targets r1 regardless of the rA field, which overlaps imm5.
   assign wbDest = isOri ? 2'd1 : rA;
   assign imm5   = {{(DATA_W-5){1'b0}}, ir_q[7:3]};
   assign imm4   = {{(DATA_W-4){ir_q[7]}}, ir_q[7:4]};

`ifdef MULTICYCLE_CORE_MUL_EN
   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic              isMul;
   logic [CNT_W-1:0]  mulCnt_q, mulCnt_d;
   logic [DATA_W-1:0] mulAcc;

   assign isMul  = (op == 4'b1010);
   assign mulAcc = aluOut_q + (opB_q[0] ? opA_q : '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mulCnt_q <= '0;
      end else begin
         mulCnt_q <= mulCnt_d;
      end
   end
`endif

   always_comb begin
      aluResult = '0;
      if (isAdd) begin
         aluResult = opA_q + opB_q;
      end else if (isSub) begin
         aluResult = opA_q - opB_q;
      end else if (isNand) begin
         aluResult = ~(opA_q & opB_q);
      end else if (isOri) begin
         aluResult = opA_q | imm5;
      end else if (isShift) begin
         aluResult = ir_q[5] ? (opA_q >> ir_q[4:3]) : (opA_q << ir_q[4:3]);
      end
   end

   // Next-state and bus control; a pending request with no ack leaves everything in place.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      regs_d   = regs_q;
      opA_d    = opA_q;
      opB_d    = opB_q;
      aluOut_d = aluOut_q;
      mdr_d    = mdr_q;
      flagN_d  = flagN_q;
      flagZ_d  = flagZ_q;
      memReq   = 1'b0;
      memWe    = 1'b0;
      memAddr  = '0;
      memWdata = '0;
`ifdef MULTICYCLE_CORE_MUL_EN
      mulCnt_d = mulCnt_q;
`endif

      case (state_q)
         FETCH: begin
            memReq  = 1'b1;
            memAddr = pc_q;
            if (mem.mem_ack) begin
               ir_d    = mem.mem_rdata[7:0];
               pc_d    = pc_q + DATA_W'(1);
               state_d = DECODE;
            end
         end

         DECODE: begin
            opA_d = isOri ? regs_q[1] : regs_q[rA];
            opB_d = regs_q[rB];
            if (isLoad || isStore) begin
               state_d = MEM;
`ifdef MULTICYCLE_CORE_MUL_EN
            end else if (isMul) begin
               aluOut_d = '0;
               mulCnt_d = '0;
               state_d  = MUL;
`endif
            end else begin
               state_d = EXEC;
            end
         end

         EXEC: begin
            if (isAlu) begin
               aluOut_d = aluResult;
               flagN_d  = aluResult[DATA_W-1];
               flagZ_d  = (aluResult == '0);
               state_d  = WB;
            end else begin
               if (branchTaken) begin
                  pc_d = pc_q + imm4;
               end
               state_d = FETCH;
            end
         end

         MEM: begin
            memReq   = 1'b1;
            memWe    = isStore;
            memAddr  = opB_q;
            memWdata = isStore ? opA_q : '0;
            if (mem.mem_ack) begin
               if (isStore) begin
                  state_d = FETCH;
               end else begin
                  mdr_d   = mem.mem_rdata;
                  state_d = WB;
               end
            end
         end

         WB: begin
            regs_d[wbDest] = isLoad ? mdr_q : aluOut_q;
            state_d        = FETCH;
         end

`ifdef MULTICYCLE_CORE_MUL_EN
         // One multiplier bit per cycle: aluOut accumulates, opA shifts up, opB shifts down.
         MUL: begin
            aluOut_d = mulAcc;
            opA_d    = opA_q << 1;
            opB_d    = opB_q >> 1;
            mulCnt_d = mulCnt_q + CNT_W'(1);
            if (mulCnt_q == CNT_W'(DATA_W - 1)) begin
               flagN_d = mulAcc[DATA_W-1];
               flagZ_d = (mulAcc == '0);
               state_d = WB;
            end
         end
`endif

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= FETCH;
         pc_q     <= PC_RESET;
         ir_q     <= '0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
         opA_q    <= '0;
         opB_q    <= '0;
         aluOut_q <= '0;
         mdr_q    <= '0;
         flagN_q  <= 1'b0;
         flagZ_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         regs_q   <= regs_d;
         opA_q    <= opA_d;
         opB_q    <= opB_d;
         aluOut_q <= aluOut_d;
         mdr_q    <= mdr_d;
         flagN_q  <= flagN_d;
         flagZ_q  <= flagZ_d;
      end
   end

   // The bus goes quiet the instant reset rises, abandoning any access in flight.
   assign mem.mem_req   = memReq & ~reset;
   assign mem.mem_we    = memWe & ~reset;
   assign mem.mem_addr  = reset ? '0 : memAddr;
   assign mem.mem_wdata = reset ? '0 : memWdata;

   assign pc     = pc_q;
   assign flag_n = flagN_q;
   assign flag_z = flagZ_q;
   assign state  = state_q;
   assign r0     = regs_q[0];
   assign r1     = regs_q[1];
   assign r2     = regs_q[2];
   assign r3     = regs_q[3];

endmodule

// File: tb/tb_multicycle_core_p.sv
// Randomised bench for multicycle_core_p: an ISA-level model predicts every bus transfer,
// register file snapshot and instruction latency; a monitor compares them as the core acks.
module tb_multicycle_core_p;

   localparam int         DW       = 8;
   localparam logic [7:0] PC_START = 8'hF4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] pc, r0, r1, r2, r3;
   logic       flag_n, flag_z;
   logic [3:0] state;

   always #5 clock = ~clock;

   multicycle_core_p_if #(.DATA_W(DW)) bus ();

   multicycle_core_p #(.DATA_W(DW), .PC_RESET(PC_START)) dut (
      .clock  (clock),
      .reset  (reset),
      .mem    (bus),
      .pc     (pc),
      .flag_n (flag_n),
      .flag_z (flag_z),
      .state  (state),
      .r0     (r0),
      .r1     (r1),
      .r2     (r2),
      .r3     (r3)
   );

   typedef struct {
      bit          isFetch;
      bit          we;
      logic [7:0]  addr;
      logic [7:0]  wdata;
      logic [31:0] regs;
      bit          n;
      bit          z;
      int          prevLat;
      bit          checkLat;
   } expItem_t;

   expItem_t   expQ[$];
   int         vectors     = 0;
   int         miscompares = 0;
   int         maxWait     = 0;
   logic [7:0] mem  [256];
   logic [7:0] mMem [256];
   logic [7:0] mR   [4];
   logic [7:0] mPc;
   bit         mN, mZ, mFirst;
   int         mLastLat;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Executes one instruction of the reference machine and queues what the bus must show.
   function automatic void modelExecute();
      expItem_t   it;
      logic [7:0] ir, res, addr;
      int         op, a, b, t, im, lat;
      bit         taken, setsFlags;
      ir = mMem[mPc];
      op = int'(ir[3:0]);
      a  = int'(ir[7:6]);
      b  = int'(ir[5:4]);
      it.isFetch  = 1'b1;
      it.we       = 1'b0;
      it.addr     = mPc;
      it.wdata    = 8'h00;
      it.regs     = {mR[3], mR[2], mR[1], mR[0]};
      it.n        = mN;
      it.z        = mZ;
      it.prevLat  = mLastLat;
      it.checkLat = !mFirst;
      expQ.push_back(it);
      mFirst    = 1'b0;
      mPc       = 8'((int'(mPc) + 1) % 256);
      lat       = 3;
      res       = 8'h00;
      setsFlags = 1'b0;
      case (op)
         0: begin
            addr        = mR[b];
            it.isFetch  = 1'b0;
            it.we       = 1'b0;
            it.addr     = addr;
            expQ.push_back(it);
            mR[a] = mMem[addr];
            lat   = 4;
         end
         2: begin
            addr        = mR[b];
            it.isFetch  = 1'b0;
            it.we       = 1'b1;
            it.addr     = addr;
            it.wdata    = mR[a];
            expQ.push_back(it);
            mMem[addr] = mR[a];
         end
         4: begin
            t = (int'(mR[a]) + int'(mR[b])) % 256;
            res = 8'(t); setsFlags = 1'b1;
         end
         6: begin
            t = (int'(mR[a]) - int'(mR[b]) + 256) % 256;
            res = 8'(t); setsFlags = 1'b1;
         end
         8: begin
            res = ~(mR[a] & mR[b]); setsFlags = 1'b1;
         end
         7, 15: begin
            res = mR[1] | {3'b000, ir[7:3]};
            a = 1; setsFlags = 1'b1;
         end
         3, 11: begin
            if (ir[5]) t = int'(mR[a]) / (1 << ir[4:3]);
            else       t = (int'(mR[a]) * (1 << ir[4:3])) % 256;
            res = 8'(t); setsFlags = 1'b1;
         end
         5, 9, 13: begin
            taken = (op == 5 && mZ) || (op == 9 && !mZ) || (op == 13 && !mN);
            im = int'(ir[7:4]);
            if (im > 7) im = im - 16;
            if (taken) mPc = 8'((int'(mPc) + im + 256) % 256);
         end
`ifdef MULTICYCLE_CORE_MUL_EN
         10: begin
            t = (int'(mR[a]) * int'(mR[b])) % 256;
            res = 8'(t); setsFlags = 1'b1;
            lat = 3 + DW;
         end
`endif
         default: lat = 3;
      endcase
      if (setsFlags) begin
         mR[a] = res;
         mN    = res[7];
         mZ    = (res == 8'h00);
         if (lat == 3) lat = 4;
      end
      mLastLat = lat;
   endfunction

   task automatic checkReset();
      checkOutput("reset.state", state, 0);
      checkOutput("reset.pc", pc, PC_START);
      checkOutput("reset.flags", {flag_n, flag_z}, 0);
      checkOutput("reset.regs", {r3, r2, r1, r0}, 0);
      checkOutput("reset.req", bus.mem_req, 0);
      checkOutput("reset.we", bus.mem_we, 0);
      checkOutput("reset.addr", bus.mem_addr, 0);
      checkOutput("reset.wdata", bus.mem_wdata, 0);
   endtask

   // Loads a fresh program under reset, predicts it, runs it (optionally aborting with reset).
   task automatic applyStimulus(input int nInstr, input int waitLimit, input bit directed, input int abortCycles);
      logic [7:0] v;
      logic [7:0] prefix [6];
      int c;
      #2 reset = 1'b1;
      #1;
      expQ.delete();
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         mem[i]  = v;
         mMem[i] = v;
      end
      if (directed) begin
         prefix = '{8'h2F, 8'h14, 8'h06, 8'h90, 8'h14, 8'h29};
         for (int i = 0; i < 6; i++) begin
            mem[8'(int'(PC_START) + i)]  = prefix[i];
            mMem[8'(int'(PC_START) + i)] = prefix[i];
         end
      end
      for (int i = 0; i < 4; i++) mR[i] = 8'h00;
      mPc = PC_START; mN = 1'b0; mZ = 1'b0; mFirst = 1'b1; mLastLat = 0;
      maxWait = waitLimit;
      for (int i = 0; i < nInstr; i++) modelExecute();
      repeat (2) @(posedge clock);
      #2 checkReset();
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      checkOutput("release.req", bus.mem_req, 1);
      checkOutput("release.addr", bus.mem_addr, PC_START);
      if (abortCycles > 0) begin
         repeat (abortCycles) @(posedge clock);
         c = 0;
         do begin
            @(negedge clock);
            c++;
         end while (!bus.mem_req && c < 50);
         checkOutput("abort.reqBefore", bus.mem_req, 1);
         #2 reset = 1'b1;
         #1 checkReset();
         expQ.delete();
      end else begin
         for (c = 0; c < 30000 && expQ.size() > 0; c++) @(posedge clock);
         if (expQ.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL timeout: %0d expected transfers left, expected 0", expQ.size());
         end
      end
   endtask

   // Memory responder: random wait states, plus stray acks while the core is not requesting.
   initial begin
      int left;
      left = -1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            bus.mem_ack = 1'b0;
            left = -1;
         end else if (!bus.mem_req) begin
            bus.mem_ack   = ($urandom_range(0, 3) == 0);
            bus.mem_rdata = 8'($urandom);
            left = -1;
         end else begin
            if (left < 0) left = (maxWait == 0) ? 0 : int'($urandom_range(0, maxWait));
            if (left == 0) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem[bus.mem_addr];
               if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
               left = -1;
            end else begin
               bus.mem_ack = 1'b0;
               left--;
            end
         end
      end
   end

   // Monitor: on every acked transfer pop the next prediction and compare.
   initial begin
      expItem_t   e;
      int         cyc, waits, lastFetch;
      bit         inWait;
      logic [7:0] hAddr, hWdata;
      logic       hWe;
      cyc = 0; waits = 0; lastFetch = 0; inWait = 1'b0;
      hAddr = '0; hWdata = '0; hWe = 1'b0;
      forever begin
         @(negedge clock);
         #1;
         cyc++;
         if (reset) begin
            waits  = 0;
            inWait = 1'b0;
            continue;
         end
         if (bus.mem_req && !bus.mem_ack) begin
            waits++;
            if (!inWait) begin
               inWait = 1'b1;
               hAddr  = bus.mem_addr;
               hWe    = bus.mem_we;
               hWdata = bus.mem_wdata;
            end
         end else if (bus.mem_req && bus.mem_ack) begin
            if (inWait) begin
               checkOutput("stable.addr", bus.mem_addr, hAddr);
               checkOutput("stable.we", bus.mem_we, hWe);
               checkOutput("stable.wdata", bus.mem_wdata, hWdata);
            end
            inWait = 1'b0;
            if (expQ.size() > 0) begin
               e = expQ.pop_front();
               checkOutput("bus.we", bus.mem_we, e.we);
               checkOutput("bus.addr", bus.mem_addr, e.addr);
               if (e.we) checkOutput("bus.wdata", bus.mem_wdata, e.wdata);
               if (e.isFetch) begin
                  checkOutput("fetch.pc", pc, e.addr);
                  checkOutput("fetch.regs", {r3, r2, r1, r0}, e.regs);
                  checkOutput("fetch.flags", {flag_n, flag_z}, {e.n, e.z});
                  checkOutput("fetch.state", state, 0);
                  if (e.checkLat) checkOutput("latency", cyc - lastFetch, e.prevLat + waits);
                  lastFetch = cyc;
                  waits     = 0;
               end
            end
         end
      end
   end

   initial begin
      $display("[TB] start");
      applyStimulus(60, 0, 1'b1, 0);
      applyStimulus(150, 3, 1'b0, 40);
      applyStimulus(250, 2, 1'b0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
